pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Control FSM that sequences the program counter register of the processor core.
- Decides each cycle whether the PC advances: sequential increment, branch target, or hold.
- Supports free-run and single-step (debug) execution, and stops on the HALT opcode.
- Sits between the debug/control interface and the pc register. It drives the pc register's next-value and write-enable inputs, and gates datapath writes through o_instr_valid.

Parameters:
NBITS, 11, PC width; must match pc register width
OPC_BITS, 5, opcode field width
HALT_OPC, 5'b00000, opcode value that stops execution
CNT_BITS, 16, width of executed-instruction counter

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  level; begins execution from IDLE
i_mode_step  in  1  1 = single-step mode, 0 = free-run
i_step  in  1  step request; rising edge executes one instruction
i_opcode  in  OPC_BITS  opcode of the instruction at the current PC
i_branch  in  1  current instruction redirects the PC
i_branch_target  in  NBITS  absolute branch destination
i_pc  in  NBITS  current PC register value
o_pc_next  out  NBITS  next PC value, to pc register
o_wr_pc  out  1  PC write enable, to pc register
o_instr_valid  out  1  current instruction executes this cycle
o_halted  out  1  HALT reached
o_state  out  2  FSM state: IDLE=00, RUN=01, WAIT_STEP=10, HALT=11
o_instr_count  out  CNT_BITS  instructions executed since reset

Behaviour:
- All state changes occur on the rising edge of i_clock. Reset is synchronous and active-high.
- Reset (any state, including mid-run) forces:
  - state=IDLE, o_halted=0, o_instr_count=0;
  - internal step-edge register=0.
  - o_wr_pc and o_instr_valid are 0 while state=IDLE.
- o_pc_next (combinational, always driven):
  - equals i_branch_target when i_branch=1;
  - otherwise equals i_pc+1, unsigned, modulo 2^NBITS (all-ones wraps to 0).
- step_edge = i_step & ~i_step_d. i_step_d is a register updated every cycle and reset to 0.
- exec (combinational):
  - RUN: exec = (i_opcode != HALT_OPC);
  - WAIT_STEP: exec = step_edge & (i_opcode != HALT_OPC);
  - all other states: exec = 0.
- o_wr_pc = o_instr_valid = exec. The PC register updates on the same edge, so latency from step edge to new PC is one cycle.
- Transitions:
  - IDLE: if i_start, go to WAIT_STEP when i_mode_step=1, else go to RUN. Otherwise stay in IDLE. No instruction executes in IDLE, and a step edge coincident with i_start is not consumed.
  - RUN: if i_opcode==HALT_OPC, go to HALT with no PC write. Else if i_mode_step=1, execute the current instruction and then go to WAIT_STEP. Else stay in RUN.
  - WAIT_STEP: if step_edge and i_opcode==HALT_OPC, go to HALT. Else if i_mode_step=0, go to RUN; a step_edge in this same cycle still executes one instruction. Else stay in WAIT_STEP.
  - HALT: terminal. o_halted=1 from the first cycle in HALT. i_start and i_step are ignored; exit only via i_reset.
- i_step held high executes exactly one instruction. Another step requires a low-then-high transition.
- o_instr_count increments by 1 on each exec cycle and saturates at 2^CNT_BITS-1 (no wrap).
- No instruction is executed twice. A HALT opcode never writes the PC, so i_pc stays pointing at HALT.

Test Plan:
- Reset, then i_start with i_mode_step=0 and opcodes non-HALT:
  - state 00→01;
  - o_wr_pc=1 every cycle, PC sequence 0,1,2,3…;
  - o_instr_count tracks the number of executed instructions.
- Free-run with i_branch=1 and i_branch_target=0x100 at PC=5:
  - o_pc_next=0x100 that cycle, next PC=0x100;
  - with i_pc=0x7FF and no branch, o_pc_next=0x000.
- Step mode: i_start with i_mode_step=1, then hold i_step high for 5 cycles:
  - exactly one o_wr_pc pulse, PC 0→1;
  - drop i_step and re-raise it: PC 1→2, o_instr_count=2.
- HALT_OPC presented at PC=7 in RUN:
  - o_wr_pc=0, state→11, o_halted=1, PC stays 7;
  - a later i_start or i_step produces no change.
- Assert i_reset for one cycle mid-RUN at PC=20:
  - next cycle: state=00, o_halted=0, o_instr_count=0, o_wr_pc=0.
- Toggle i_mode_step 1→0 while in WAIT_STEP with step_edge in the same cycle:
  - one instruction executes, state→RUN;
  - continuous execution follows.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencing FSM. Each cycle it decides whether
//                the PC advances (sequential increment or branch target) or
//                holds. Supports free-run and single-step execution and stops
//                on the HALT opcode.
//
//  Ports       : i_clock / i_reset    clock, synchronous active-high reset
//                i_start              level, leaves IDLE
//                i_mode_step          1 = single-step, 0 = free-run
//                i_step               step request (rising edge = one instr)
//                i_opcode             opcode at current PC
//                i_branch             current instruction redirects the PC
//                i_branch_target      absolute branch destination
//                i_pc                 current PC register value
//                o_pc_next            next PC value to the pc register
//                o_wr_pc              pc register write enable
//                o_instr_valid        current instruction executes this cycle
//                o_halted             HALT reached
//                o_state              IDLE=00 RUN=01 WAIT_STEP=10 HALT=11
//                o_instr_count        saturating executed-instruction count
//
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer #(
  parameter int                  NBITS    = 11,
  parameter int                  OPC_BITS = 5,
  parameter logic [OPC_BITS-1:0] HALT_OPC = 5'b00000,
  parameter int                  CNT_BITS = 16
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_mode_step,
  input  logic                i_step,
  input  logic [OPC_BITS-1:0] i_opcode,
  input  logic                i_branch,
  input  logic [NBITS-1:0]    i_branch_target,
  input  logic [NBITS-1:0]    i_pc,
  output logic [NBITS-1:0]    o_pc_next,
  output logic                o_wr_pc,
  output logic                o_instr_valid,
  output logic                o_halted,
  output logic [1:0]          o_state,
  output logic [CNT_BITS-1:0] o_instr_count
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_RUN       = 2'b01,
    S_WAIT_STEP = 2'b10,
    S_HALT      = 2'b11
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  state_t              state_q, state_d;
  logic                step_dly_q, step_dly_d;
  logic [CNT_BITS-1:0] count_q, count_d;

  logic w_step_edge;
  logic w_is_halt;
  logic w_exec;

  // Next-PC mux is independent of the FSM; the write enable decides whether
  // the pc register actually takes it. Increment wraps naturally at NBITS.
  always_comb begin
    o_pc_next = i_branch ? i_branch_target : (i_pc + NBITS'(1));
  end

  always_comb begin
    w_step_edge = i_step & ~step_dly_q;
    w_is_halt   = (i_opcode == HALT_OPC);
    step_dly_d  = i_step;
    state_d     = state_q;
    w_exec      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A step edge that coincides with i_start is not consumed here.
        if (i_start) begin
          state_d = i_mode_step ? S_WAIT_STEP : S_RUN;
        end
      end
      S_RUN: begin
        if (w_is_halt) begin
          state_d = S_HALT;
        end else begin
          w_exec = 1'b1;
          if (i_mode_step) begin
            state_d = S_WAIT_STEP;
          end
        end
      end
      S_WAIT_STEP: begin
        // A step edge in the same cycle as the switch to free-run still
        // executes exactly one instruction.
        w_exec = w_step_edge & ~w_is_halt;
        if (w_step_edge && w_is_halt) begin
          state_d = S_HALT;
        end else if (!i_mode_step) begin
          state_d = S_RUN;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    count_d = count_q;
    if (w_exec && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      step_dly_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      step_dly_q <= step_dly_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    o_wr_pc       = w_exec;
    o_instr_valid = w_exec;
    o_halted      = (state_q == S_HALT);
    o_state       = state_q;
    o_instr_count = count_q;
  end

endmodule
`default_nettype wire
